lfo_scheduler: RTL and testbench
================================

# lfo_scheduler

Time-shares one sine DDS lookup unit between NCH low-frequency-oscillator channels (tremolo, vibrato, chorus sweep) in the audio effects chain. Each channel has its own tick-period counter and phase accumulator. A round-robin arbiter issues at most one phase request per cycle to the shared DDS. Returned samples are tagged back to their channel, inverted around midscale, and held on per-channel outputs with a one-cycle strobe.

## Interface
- NCH, 4: number of LFO channels (2..8)
- PHASE_W, 6: DDS phase width; phase wraps modulo 2^PHASE_W
- AMP_W, 6: DDS sine sample width and lfo_out width per channel
- CNT_W, 30: period counter width
- DDS_LAT, 2: fixed cycles from dds_phase_valid to dds_valid (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ch_en  in  NCH  per-channel enable
- period  in  NCH*CNT_W  per-channel tick period; channel k occupies bits [k*CNT_W +: CNT_W]
- dds_phase_valid  out  1  request strobe to shared DDS
- dds_phase  out  PHASE_W  phase presented with the request
- dds_sine  in  AMP_W  DDS sample
- dds_valid  in  1  DDS sample valid
- lfo_out  out  NCH*AMP_W  per-channel held LFO value
- lfo_strobe  out  NCH  one-cycle pulse when the matching lfo_out slice updates
- overrun  out  NCH  sticky: a tick was dropped because the previous one was still pending
- lat_err  out  1  sticky: dds_valid disagreed with the expected tag pipeline

## Operation
- Reset values:
  - All counters, phases and pending flags are 0.
  - Round-robin pointer is 0.
  - dds_phase_valid, dds_phase, lfo_strobe, overrun and lat_err are 0.
  - Every lfo_out slice is 2^(AMP_W-1) (midscale, 32 at the default width).
- Per-channel counter (when ch_en[k]=1):
  - cnt increments each cycle.
  - When cnt ≥ period[k], cnt←0 and a tick fires.
  - The tick interval is therefore period+1 cycles; period=0 gives a tick every cycle.
- Tick handling:
  - A tick sets pending[k].
  - A tick arriving while pending[k] is already set and not being granted that cycle sets overrun[k]; the tick is dropped, not queued.
- Arbiter:
  - Among the pending channels, grant the first at or after the pointer, wrapping modulo NCH.
  - At most one grant per cycle.
  - After granting k, pointer←(k+1) mod NCH.
  - With nothing pending, the pointer holds.
- Grant to k:
  - dds_phase_valid←1 and dds_phase←phase[k] (registered).
  - phase[k]←phase[k]+1, wrapping modulo 2^PHASE_W (63→0).
  - pending[k] is cleared, unless a new tick for k fires the same cycle; then it stays set with no overrun.
- Tag pipeline:
  - A DDS_LAT-deep shift register of {valid, channel index} advances every cycle.
  - Its output aligns with the expected dds_valid.
- Return path:
  - When dds_valid=1 and the tag is valid for channel k: lfo_out[k]←(2^(AMP_W-1) − dds_sine) mod 2^AMP_W and lfo_strobe[k]←1 for one cycle.
  - If ch_en[k] has since dropped, the sample is discarded: no update, no strobe.
  - If dds_valid ≠ tag valid, lat_err←1 (sticky until reset) and no output updates.
- Disable (ch_en[k]=0):
  - cnt, pending and phase of channel k are held at 0.
  - lfo_out[k] holds its last value.
  - overrun[k] is unaffected.
- overrun and lat_err clear only on reset.

## Timing
- Tick cycle T sets pending at T+1.
- An uncontended grant is visible on dds_phase_valid at T+2.
- lfo_out and lfo_strobe update one cycle after dds_valid, i.e. T+2+DDS_LAT+1 after the tick.
- Worst-case grant wait is NCH−1 cycles after pending is set.
- Sustained throughput is one channel per cycle. Overrun is impossible while every period ≥ NCH−1.
- Asynchronous reset mid-operation clears the tag pipeline. Any DDS samples arriving after reset are untagged and set lat_err, unless the DDS unit is reset by the same rst_n (the required system arrangement).

## Test plan
- Single channel:
  - Stimulus: ch_en=0001, period0=3, DDS model returns dds_sine=phase.
  - Required: dds_phase sequence 0,1,2,… with one request every 4 cycles; lfo_out0 sequence 32,31,30,…
  - Wrap: phase 63 → lfo_out0=(32−63) mod 64=33, and the next dds_phase is 0.
- All four channels, period=0:
  - Required: grants rotate 0,1,2,3,0…, one per cycle.
  - overrun sets on every channel, since each ticks every cycle but is served every 4 cycles.
- Four channels, period=3:
  - Required: round-robin service with no overrun, and each channel phase advances exactly once per 4 cycles.
- Simultaneous events:
  - Tick fires on the same cycle channel 2 is granted: pending2 remains 1, overrun2 remains 0.
- Disable with request in flight:
  - Drop ch_en1 one cycle after its grant.
  - Required: no lfo_strobe1, lfo_out1 unchanged, and phase1 reads 0 after re-enable.
- Latency fault and reset:
  - DDS model injects dds_valid with no request outstanding → lat_err=1.
  - Assert rst_n low mid-stream → all outputs return to reset values, lfo_out slices to 32.

Source files
------------

// File: rtl/lfo_scheduler.sv
// Time-shared sine DDS scheduler for NCH low-frequency oscillators: per-channel
// tick counters and phase accumulators, round-robin request arbitration, tagged return path.
module lfo_scheduler #(
  parameter int NCH     = 4,
  parameter int PHASE_W = 6,
  parameter int AMP_W   = 6,
  parameter int CNT_W   = 30,
  parameter int DDS_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         ch_en,
  input  logic [NCH*CNT_W-1:0]   period,
  output logic                   dds_phase_valid,
  output logic [PHASE_W-1:0]     dds_phase,
  input  logic [AMP_W-1:0]       dds_sine,
  input  logic                   dds_valid,
  output logic [NCH*AMP_W-1:0]   lfo_out,
  output logic [NCH-1:0]         lfo_strobe,
  output logic [NCH-1:0]         overrun,
  output logic                   lat_err
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AMP_W-1:0] MID = {1'b1, {(AMP_W-1){1'b0}}};

  logic [NCH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0][PHASE_W-1:0] phase_q, phase_d;
  logic [NCH-1:0]              pending_q, pending_d;
  logic [NCH-1:0]              overrun_q, overrun_d;
  logic [NCH-1:0]              strobe_q, strobe_d;
  logic [NCH-1:0][AMP_W-1:0]   lfo_q, lfo_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic [IDX_W-1:0]            req_ch_q, req_ch_d;
  logic                        req_vld_q, req_vld_d;
  logic [PHASE_W-1:0]          req_phase_q, req_phase_d;
  logic [DDS_LAT-1:0]          tag_vld_q, tag_vld_d;
  logic [DDS_LAT-1:0][IDX_W-1:0] tag_ch_q, tag_ch_d;
  logic                        lat_err_q, lat_err_d;

  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   eligible;
  logic             gnt_found;
  logic [IDX_W-1:0] gnt_ch;
  logic [IDX_W:0]   cand;
  logic             ret_vld;
  logic [IDX_W-1:0] ret_ch;

  assign eligible = pending_q & ch_en;

  // Round-robin search: first eligible channel at or after the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    cand      = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NCH)) cand = cand - (IDX_W+1)'(NCH);
      if (!gnt_found && eligible[cand[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_ch    = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    tick      = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!ch_en[k]) begin
        cnt_d[k]     = '0;
        phase_d[k]   = '0;
        pending_d[k] = 1'b0;
      end else begin
        tick[k]  = (cnt_q[k] >= period[k*CNT_W +: CNT_W]);
        cnt_d[k] = tick[k] ? '0 : cnt_q[k] + CNT_W'(1);
        // A tick coinciding with the grant re-arms pending instead of overrunning.
        if (gnt_found && gnt_ch == IDX_W'(k)) begin
          pending_d[k] = tick[k];
          phase_d[k]   = phase_q[k] + PHASE_W'(1);
        end else if (tick[k]) begin
          if (pending_q[k]) overrun_d[k] = 1'b1;
          pending_d[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_vld_d   = gnt_found;
    req_ch_d    = gnt_ch;
    req_phase_d = gnt_found ? phase_q[gnt_ch] : req_phase_q;
    ptr_d       = ptr_q;
    if (gnt_found) ptr_d = (gnt_ch == IDX_W'(NCH-1)) ? '0 : gnt_ch + IDX_W'(1);

    // Tags enter from the registered request so the last stage lines up with dds_valid.
    tag_vld_d    = tag_vld_q;
    tag_ch_d     = tag_ch_q;
    tag_vld_d[0] = req_vld_q;
    tag_ch_d[0]  = req_ch_q;
    for (int i = 1; i < DDS_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_ch_d[i]  = tag_ch_q[i-1];
    end

    ret_vld   = tag_vld_q[DDS_LAT-1];
    ret_ch    = tag_ch_q[DDS_LAT-1];
    lfo_d     = lfo_q;
    strobe_d  = '0;
    lat_err_d = lat_err_q;
    if (dds_valid != ret_vld) begin
      lat_err_d = 1'b1;
    end else if (dds_valid && ch_en[ret_ch]) begin
      lfo_d[ret_ch]    = MID - dds_sine;
      strobe_d[ret_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      phase_q     <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      strobe_q    <= '0;
      lfo_q       <= {NCH{MID}};
      ptr_q       <= '0;
      req_ch_q    <= '0;
      req_vld_q   <= 1'b0;
      req_phase_q <= '0;
      tag_vld_q   <= '0;
      tag_ch_q    <= '0;
      lat_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      strobe_q    <= strobe_d;
      lfo_q       <= lfo_d;
      ptr_q       <= ptr_d;
      req_ch_q    <= req_ch_d;
      req_vld_q   <= req_vld_d;
      req_phase_q <= req_phase_d;
      tag_vld_q   <= tag_vld_d;
      tag_ch_q    <= tag_ch_d;
      lat_err_q   <= lat_err_d;
    end
  end

  assign dds_phase_valid = req_vld_q;
  assign dds_phase       = req_phase_q;
  assign lfo_out         = lfo_q;
  assign lfo_strobe      = strobe_q;
  assign overrun         = overrun_q;
  assign lat_err         = lat_err_q;

endmodule

// File: tb/tb_lfo_scheduler.sv
// Directed bench for lfo_scheduler: scenario table plus hand-written corner sequences,
// with a fixed-latency DDS stand-in that returns dds_sine equal to the requested phase.
module tb_lfo_scheduler;

  localparam int NCH = 4, PHASE_W = 6, AMP_W = 6, CNT_W = 30, DDS_LAT = 2;
  localparam logic [NCH*AMP_W-1:0] MIDALL = {NCH{6'd32}};

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       chEn = '0;
  logic [NCH*CNT_W-1:0] period = '0;
  logic                 dds_phase_valid;
  logic [PHASE_W-1:0]   dds_phase;
  logic [AMP_W-1:0]     dds_sine;
  logic                 dds_valid;
  logic [NCH*AMP_W-1:0] lfo_out;
  logic [NCH-1:0]       lfo_strobe;
  logic [NCH-1:0]       overrun;
  logic                 lat_err;
  logic                 inject = 1'b0;

  int compares = 0;
  int fails = 0;
  int cyc = 0;

  lfo_scheduler #(.NCH(NCH), .PHASE_W(PHASE_W), .AMP_W(AMP_W), .CNT_W(CNT_W), .DDS_LAT(DDS_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(chEn), .period(period),
    .dds_phase_valid(dds_phase_valid), .dds_phase(dds_phase),
    .dds_sine(dds_sine), .dds_valid(dds_valid),
    .lfo_out(lfo_out), .lfo_strobe(lfo_strobe), .overrun(overrun), .lat_err(lat_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DDS stand-in sharing rst_n with the scheduler
  logic mv0, mv1;
  logic [PHASE_W-1:0] mp0, mp1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv0 <= 1'b0; mv1 <= 1'b0; mp0 <= '0; mp1 <= '0;
    end else begin
      mv0 <= dds_phase_valid; mp0 <= dds_phase;
      mv1 <= mv0;             mp1 <= mp0;
    end
  end
  assign dds_valid = mv1 | inject;
  assign dds_sine  = mp1;

  typedef struct { int cycle; logic [PHASE_W-1:0] phase; } reqRec_t;
  typedef struct { logic [NCH-1:0] strobe; logic [NCH*AMP_W-1:0] lfo; } strRec_t;
  reqRec_t reqQ[$];
  strRec_t strQ[$];

  always @(negedge clk) begin
    if (dds_phase_valid) reqQ.push_back('{cyc, dds_phase});
    if (|lfo_strobe) strQ.push_back('{lfo_strobe, lfo_out});
  end

  typedef struct {
    logic [NCH-1:0]   en;
    logic [CNT_W-1:0] per;
    int               nReq;
    int               gap;
    logic [NCH-1:0]   expOvr;
  } scen_t;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compares++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] en, input logic [CNT_W-1:0] per);
    chEn   = en;
    period = {NCH{per}};
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n  = 1'b0;
    inject = 1'b0;
    applyStimulus('0, '0);
    repeat (2) @(negedge clk);
    reqQ.delete();
    strQ.delete();
    rst_n = 1'b1;
  endtask

  task automatic waitReq(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dds_phase_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(name, 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    scen_t scen [5];
    int    enList [NCH];
    int    nEn;
    int    ch;
    logic [PHASE_W-1:0] expPh;
    logic [AMP_W-1:0]   expLfo;

    scen[0] = '{4'b0001, 30'd3, 66, 4, 4'b0000};
    scen[1] = '{4'b1111, 30'd0, 16, 1, 4'b1111};
    scen[2] = '{4'b1111, 30'd3, 16, 1, 4'b0000};
    scen[3] = '{4'b0100, 30'd0, 12, 1, 4'b0000};
    scen[4] = '{4'b0101, 30'd0, 12, 1, 4'b0101};

    doReset();
    @(negedge clk);
    checkOutput("rst dds_phase_valid", 64'(dds_phase_valid), 64'd0);
    checkOutput("rst dds_phase", 64'(dds_phase), 64'd0);
    checkOutput("rst lfo_strobe", 64'(lfo_strobe), 64'd0);
    checkOutput("rst overrun", 64'(overrun), 64'd0);
    checkOutput("rst lat_err", 64'(lat_err), 64'd0);
    checkOutput("rst lfo_out", 64'(lfo_out), 64'(MIDALL));

    for (int s = 0; s < 5; s++) begin
      doReset();
      applyStimulus(scen[s].en, scen[s].per);
      repeat (16 + scen[s].nReq * scen[s].gap) @(negedge clk);

      nEn = 0;
      for (int k = 0; k < NCH; k++) begin
        if (scen[s].en[k]) begin
          enList[nEn] = k;
          nEn++;
        end
      end

      checkOutput($sformatf("s%0d reqCount", s),
                  64'((reqQ.size() >= scen[s].nReq) ? scen[s].nReq : reqQ.size()), 64'(scen[s].nReq));
      checkOutput($sformatf("s%0d strobeCount", s),
                  64'((strQ.size() >= scen[s].nReq) ? scen[s].nReq : strQ.size()), 64'(scen[s].nReq));
      for (int n = 0; n < scen[s].nReq; n++) begin
        expPh  = PHASE_W'(n / nEn);
        expLfo = 6'd32 - expPh;
        ch     = enList[n % nEn];
        if (n < reqQ.size()) begin
          checkOutput($sformatf("s%0d req%0d phase", s, n), 64'(reqQ[n].phase), 64'(expPh));
          if (n > 0)
            checkOutput($sformatf("s%0d req%0d gap", s, n),
                        64'(reqQ[n].cycle - reqQ[n-1].cycle), 64'(scen[s].gap));
        end
        if (n < strQ.size()) begin
          checkOutput($sformatf("s%0d ret%0d strobe", s, n), 64'(strQ[n].strobe), 64'(4'b0001 << ch));
          checkOutput($sformatf("s%0d ret%0d lfo", s, n), 64'(strQ[n].lfo[ch*AMP_W +: AMP_W]), 64'(expLfo));
        end
      end
      checkOutput($sformatf("s%0d overrun", s), 64'(overrun), 64'(scen[s].expOvr));
      checkOutput($sformatf("s%0d lat_err", s), 64'(lat_err), 64'd0);
      applyStimulus('0, scen[s].per);
      repeat (6) @(negedge clk);
      checkOutput($sformatf("s%0d overrun held", s), 64'(overrun), 64'(scen[s].expOvr));
    end

    // Disable channel 1 while its second request (phase 1) is in flight
    doReset();
    applyStimulus(4'b0010, 30'd3);
    waitReq("dis req0 seen");
    checkOutput("dis req0 phase", 64'(dds_phase), 64'd0);
    waitReq("dis req1 seen");
    checkOutput("dis req1 phase", 64'(dds_phase), 64'd1);
    applyStimulus(4'b0000, 30'd3);
    repeat (8) @(negedge clk);
    checkOutput("dis strobeCount", 64'(strQ.size()), 64'd1);
    checkOutput("dis lfo_out1", 64'(lfo_out[1*AMP_W +: AMP_W]), 64'd32);
    checkOutput("dis lfo_strobe", 64'(lfo_strobe), 64'd0);
    checkOutput("dis lat_err", 64'(lat_err), 64'd0);
    applyStimulus(4'b0010, 30'd3);
    waitReq("reen req seen");
    checkOutput("reen phase", 64'(dds_phase), 64'd0);

    // Unsolicited dds_valid, then asynchronous reset mid-stream
    doReset();
    repeat (3) @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    checkOutput("lat lat_err", 64'(lat_err), 64'd1);
    checkOutput("lat lfo_strobe", 64'(lfo_strobe), 64'd0);
    checkOutput("lat lfo_out", 64'(lfo_out), 64'(MIDALL));
    applyStimulus(4'b1111, 30'd0);
    repeat (20) @(negedge clk);
    checkOutput("mid lfo_out moved", 64'(lfo_out != MIDALL), 64'd1);
    checkOutput("mid dds_phase_valid", 64'(dds_phase_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst dds_phase_valid", 64'(dds_phase_valid), 64'd0);
    checkOutput("arst dds_phase", 64'(dds_phase), 64'd0);
    checkOutput("arst lfo_strobe", 64'(lfo_strobe), 64'd0);
    checkOutput("arst overrun", 64'(overrun), 64'd0);
    checkOutput("arst lat_err", 64'(lat_err), 64'd0);
    checkOutput("arst lfo_out", 64'(lfo_out), 64'(MIDALL));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus('0, '0);
    repeat (4) @(negedge clk);
    checkOutput("post lat_err", 64'(lat_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
